// File: rtl/fft_ctrl_pkg.sv
// Shared types and width helpers for the FFT stage sequencer.
// The optional inverse-transform feature is controlled by FFT_INVERSE_EN in the top module.
package fft_ctrl_pkg;

    localparam int FFT_NSTAGES       = 7;
    localparam int FFT_BLK_PER_STAGE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fft_drain_timer.sv
// Loadable down-counter timing the inter-stage pipeline drain.
// expired is high during the last cycle of a PIPE_LAT-long drain window.
module fft_drain_timer
    import fft_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int CW = cnt_width(PIPE_LAT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(PIPE_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == CW'(1));

endmodule

// File: rtl/fft_coeff_stage_sequencer.sv
// Steps the butterfly array through NSTAGES stages of BLK_PER_STAGE coefficient-bank issues.
// Build option FFT_INVERSE_EN adds i_inverse, latched at start and driven out as o_conj.
//
//  state | meaning
//  IDLE  | waiting for i_start, all outputs quiet
//  ISSUE | presenting o_stage/o_blk/o_bank with o_valid, advancing on i_ready
//  DRAIN | PIPE_LAT idle cycles letting the butterfly pipeline empty
//  DONE  | one-cycle o_done, then back to IDLE
module fft_coeff_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int NBITS         = 11,
    parameter int N             = 32,
    parameter int NSTAGES       = FFT_NSTAGES,
    parameter int BLK_PER_STAGE = FFT_BLK_PER_STAGE,
    parameter int PIPE_LAT      = 3,
    localparam int SW = width_of(NSTAGES),
    localparam int BW = width_of(BLK_PER_STAGE),
    localparam int KW = width_of(NSTAGES * BLK_PER_STAGE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
`ifdef FFT_INVERSE_EN
    input  logic          i_inverse,
`endif
    input  logic          i_ready,
    output logic          o_valid,
    output logic [SW-1:0] o_stage,
    output logic [BW-1:0] o_blk,
    output logic [KW-1:0] o_bank,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_start_ignored,
    output logic          o_conj
);

    if (NBITS < 1 || N < 1 || NSTAGES < 1 || BLK_PER_STAGE < 1 || PIPE_LAT < 0) begin : g_bad_cfg
        $error("fft_coeff_stage_sequencer: invalid parameter set");
    end

    localparam logic [SW-1:0] STAGE_LAST = SW'(NSTAGES - 1);
    localparam logic [BW-1:0] BLK_LAST   = BW'(BLK_PER_STAGE - 1);
    localparam logic          ONE_BLK    = (BLK_PER_STAGE == 1);

    state_t state;
    logic   last_xfer;
    logic   drain_load;
    logic   drain_expired;

    function automatic logic [KW-1:0] bank_of(input logic [SW-1:0] s, input logic [BW-1:0] b);
        return KW'(s) * KW'(BLK_PER_STAGE) + KW'(b);
    endfunction

    assign last_xfer  = (state == ISSUE) && i_ready && (o_blk == BLK_LAST);
    assign drain_load = last_xfer && (PIPE_LAT != 0);

    fft_drain_timer #(
        .PIPE_LAT (PIPE_LAT)
    ) u_drain_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (drain_load),
        .expired (drain_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            o_valid         <= 1'b0;
            o_stage         <= '0;
            o_blk           <= '0;
            o_bank          <= '0;
            o_last          <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_start_ignored <= 1'b0;
            o_conj          <= 1'b0;
        end else begin
            o_done          <= 1'b0;
            o_start_ignored <= (state != IDLE) && i_start;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= ISSUE;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b1;
                        o_stage <= '0;
                        o_blk   <= '0;
                        o_bank  <= '0;
                        o_last  <= ONE_BLK;
`ifdef FFT_INVERSE_EN
                        o_conj  <= i_inverse;
`endif
                    end
                end
                ISSUE: begin
                    if (i_ready && (o_blk != BLK_LAST)) begin
                        o_blk  <= o_blk + BW'(1);
                        o_bank <= o_bank + KW'(1);
                        o_last <= ((o_blk + BW'(1)) == BLK_LAST);
                    end else if (i_ready) begin
                        o_blk <= '0;
                        if (PIPE_LAT != 0) begin
                            state   <= DRAIN;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_bank  <= bank_of(o_stage, '0);
                        end else if (o_stage == STAGE_LAST) begin
                            state   <= DONE;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_done  <= 1'b1;
                            o_bank  <= bank_of(o_stage, '0);
                        end else begin
                            // zero-latency build rolls straight into the next stage
                            o_stage <= o_stage + SW'(1);
                            o_bank  <= o_bank + KW'(1);
                            o_last  <= ONE_BLK;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_expired && (o_stage == STAGE_LAST)) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else if (drain_expired) begin
                        state   <= ISSUE;
                        o_valid <= 1'b1;
                        o_stage <= o_stage + SW'(1);
                        o_bank  <= bank_of(o_stage + SW'(1), '0);
                        o_last  <= ONE_BLK;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_conj  <= 1'b0;
                    o_stage <= '0;
                    o_bank  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
